// File: rtl/timer.sv
// DMG-style timer: free-running divider, TIMA/TMA/TAC registers, and a
// delayed TMA reload with a one-clk interrupt pulse after TIMA overflow.
module timer #(
    parameter int unsigned RELOAD_DELAY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  t_cycle,
    input  logic [15:0] mem_addr,
    input  logic        mem_enable,
    input  logic        mem_write,
    input  logic [7:0]  mem_data_in,
    output logic [7:0]  mem_data_out,
    output logic        mem_select,
    output logic        irq_timer
);

    localparam int unsigned CNT_W = (RELOAD_DELAY > 1) ? $clog2(RELOAD_DELAY + 1) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_RELOAD  = 2'd2;

    logic [15:0]      div_q,   div_d;
    logic [7:0]       tima_q,  tima_d;
    logic [7:0]       tma_q,   tma_d;
    logic [2:0]       tac_q,   tac_d;
    logic             tick_q,  tick_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             irq_q,   irq_d;

    logic we_c, we_div_c, we_tima_c, we_tma_c, we_tac_c;
    logic tap_c, tick_c, fall_c;

    // Bus decode: FF04..FF07 share the upper 14 address bits.
    assign mem_select = mem_enable && (mem_addr[15:2] == 14'h3FC1);
    assign we_c       = mem_select && mem_write && (t_cycle == 2'd3);
    assign we_div_c   = we_c && (mem_addr[1:0] == 2'd0);
    assign we_tima_c  = we_c && (mem_addr[1:0] == 2'd1);
    assign we_tma_c   = we_c && (mem_addr[1:0] == 2'd2);
    assign we_tac_c   = we_c && (mem_addr[1:0] == 2'd3);

    always_comb begin
        mem_data_out = 8'hFF;
        if (mem_select) begin
            case (mem_addr[1:0])
                2'd0:    mem_data_out = div_q[15:8];
                2'd1:    mem_data_out = tima_q;
                2'd2:    mem_data_out = tma_q;
                default: mem_data_out = {5'b11111, tac_q};
            endcase
        end
    end

    always_comb begin
        case (tac_q[1:0])
            2'd0:    tap_c = div_q[9];
            2'd1:    tap_c = div_q[3];
            2'd2:    tap_c = div_q[5];
            default: tap_c = div_q[7];
        endcase
    end

    // The enable bit is part of tick, so DIV/TAC writes can produce a falling edge.
    assign tick_c = tac_q[2] && tap_c;
    assign fall_c = tick_q && !tick_c;

    always_comb begin
        div_d   = we_div_c ? 16'h0000 : div_q + 16'd1;
        tma_d   = we_tma_c ? mem_data_in : tma_q;
        tac_d   = we_tac_c ? mem_data_in[2:0] : tac_q;
        tick_d  = tick_c;
        tima_d  = tima_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        irq_d   = 1'b0;

        case (state_q)
            ST_PENDING: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Reload edge: TMA (including a same-edge TMA write) beats a TIMA write.
                    tima_d  = tma_d;
                    irq_d   = 1'b1;
                    state_d = ST_RELOAD;
                end else if (we_tima_c) begin
                    tima_d  = mem_data_in;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (we_tima_c) begin
                    tima_d = mem_data_in;
                end else if (fall_c) begin
                    if (tima_q == 8'hFF) begin
                        tima_d  = 8'h00;
                        cnt_d   = CNT_W'(RELOAD_DELAY);
                        state_d = ST_PENDING;
                    end else begin
                        tima_d = tima_q + 8'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= 16'h0000;
            tima_q  <= 8'h00;
            tma_q   <= 8'h00;
            tac_q   <= 3'b000;
            tick_q  <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            tima_q  <= tima_d;
            tma_q   <= tma_d;
            tac_q   <= tac_d;
            tick_q  <= tick_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
        end
    end

    assign irq_timer = irq_q;

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: cycle-level reference model plus directed
// scenarios for divider wrap, overflow reload, write races and reset.
module tb_timer;

    localparam int unsigned RELOAD_DELAY = 4;

    logic        clk;
    logic        reset;
    logic [1:0]  t_cycle;
    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        mem_write;
    logic [7:0]  mem_data_in;
    logic [7:0]  mem_data_out;
    logic        mem_select;
    logic        irq_timer;

    int total = 0;
    int bad   = 0;

    timer #(.RELOAD_DELAY(RELOAD_DELAY)) dut (
        .clk          (clk),
        .reset        (reset),
        .t_cycle      (t_cycle),
        .mem_addr     (mem_addr),
        .mem_enable   (mem_enable),
        .mem_write    (mem_write),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_select   (mem_select),
        .irq_timer    (irq_timer)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model state
    logic [15:0] m_div;
    logic [7:0]  m_tima;
    logic [7:0]  m_tma;
    logic [2:0]  m_tac;
    logic        m_prev;
    int          m_pend;
    logic        m_irq;

    function automatic logic m_tick();
        int          idx;
        logic [15:0] sh;
        case (m_tac[1:0])
            2'd0:    idx = 9;
            2'd1:    idx = 3;
            2'd2:    idx = 5;
            default: idx = 7;
        endcase
        sh = m_div >> idx;
        return m_tac[2] & sh[0];
    endfunction

    function automatic logic [7:0] m_read(input logic [15:0] a);
        case (a)
            16'hFF04: return m_div[15:8];
            16'hFF05: return m_tima;
            16'hFF06: return m_tma;
            16'hFF07: return {5'b11111, m_tac};
            default:  return 8'hFF;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin : model
        logic we;
        logic tk;
        logic fall;
        if (!reset) begin
            m_div  = 16'h0000;
            m_tima = 8'h00;
            m_tma  = 8'h00;
            m_tac  = 3'b000;
            m_prev = 1'b0;
            m_pend = 0;
            m_irq  = 1'b0;
        end else begin
            we   = mem_enable && mem_write && (t_cycle == 2'd3) &&
                   (mem_addr >= 16'hFF04) && (mem_addr <= 16'hFF07);
            tk   = m_tick();
            fall = m_prev && !tk;
            m_irq = 1'b0;
            if (m_pend > 0) begin
                m_pend = m_pend - 1;
                if (m_pend == 0) begin
                    m_tima = (we && mem_addr == 16'hFF06) ? mem_data_in : m_tma;
                    m_irq  = 1'b1;
                end else if (we && mem_addr == 16'hFF05) begin
                    m_tima = mem_data_in;
                    m_pend = 0;
                end
            end else if (we && mem_addr == 16'hFF05) begin
                m_tima = mem_data_in;
            end else if (fall) begin
                if (m_tima == 8'hFF) begin
                    m_tima = 8'h00;
                    m_pend = RELOAD_DELAY;
                end else begin
                    m_tima = m_tima + 8'd1;
                end
            end
            if (we && mem_addr == 16'hFF06) m_tma = mem_data_in;
            if (we && mem_addr == 16'hFF07) m_tac = mem_data_in[2:0];
            m_div  = (we && mem_addr == 16'hFF04) ? 16'h0000 : m_div + 16'd1;
            m_prev = tk;
        end
    end

    always @(negedge clk) begin : compare
        logic exp_sel;
        exp_sel = mem_enable && (mem_addr >= 16'hFF04) && (mem_addr <= 16'hFF07);
        check("cyc_select", 16'(mem_select), 16'(exp_sel));
        check("cyc_rdata", 16'(mem_data_out), 16'(exp_sel ? m_read(mem_addr) : 8'hFF));
        check("cyc_irq", 16'(irq_timer), 16'(m_irq));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string name);
        mem_addr   = a;
        mem_enable = 1'b1;
        mem_write  = 1'b0;
        #1;
        check(name, 16'(mem_data_out), 16'(exp));
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic [1:0] tc);
        mem_addr    = a;
        mem_data_in = d;
        mem_enable  = 1'b1;
        mem_write   = 1'b1;
        t_cycle     = tc;
        cyc(1);
        mem_write   = 1'b0;
        t_cycle     = 2'd0;
        mem_addr    = 16'hFF05;
    endtask

    task automatic poll(input logic [15:0] a, input logic [7:0] v, input int bound, input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            cyc(1);
            mem_addr   = a;
            mem_enable = 1'b1;
            mem_write  = 1'b0;
            #1;
            if (mem_data_out == v) begin
                found = 1'b1;
                break;
            end
        end
        check(name, 16'(found), 16'd1);
    endtask

    // Waits for divider bit 9, visible as DIV bit 1.
    task automatic wait_div9(input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 700; i++) begin
            cyc(1);
            mem_addr   = 16'hFF04;
            mem_enable = 1'b1;
            #1;
            if (mem_data_out[1]) begin
                found = 1'b1;
                break;
            end
        end
        check(name, 16'(found), 16'd1);
    endtask

    initial begin : stim
        int   n;
        logic seen;
        reset       = 1'b0;
        t_cycle     = 2'd0;
        mem_addr    = 16'hFF05;
        mem_enable  = 1'b0;
        mem_write   = 1'b0;
        mem_data_in = 8'h00;
        cyc(2);

        rd(16'hFF04, 8'h00, "rst_div");
        rd(16'hFF05, 8'h00, "rst_tima");
        rd(16'hFF06, 8'h00, "rst_tma");
        rd(16'hFF07, 8'hF8, "rst_tac");
        check("rst_irq", 16'(irq_timer), 16'd0);
        mem_enable = 1'b0;
        #1;
        check("rst_unselected", 16'(mem_data_out), 16'h00FF);
        reset = 1'b1;

        // Divider counts from release
        cyc(255);
        rd(16'hFF04, 8'h00, "div_255");
        cyc(1);
        rd(16'hFF04, 8'h01, "div_256");
        cyc(65535 - 256);
        rd(16'hFF04, 8'hFF, "div_ffff");
        cyc(1);
        rd(16'hFF04, 8'h00, "div_wrap");

        // Write qualification by t_cycle and out-of-range address
        wr(16'hFF07, 8'h07, 2'd1);
        rd(16'hFF07, 8'hF8, "tac_tcycle1");
        wr(16'hFF07, 8'h07, 2'd3);
        rd(16'hFF07, 8'hFF, "tac_tcycle3");
        rd(16'hFF08, 8'hFF, "ff08_data");
        check("ff08_select", 16'(mem_select), 16'd0);
        wr(16'hFF07, 8'h00, 2'd3);

        // Overflow then delayed reload with interrupt
        wr(16'hFF04, 8'h00, 2'd3);
        wr(16'hFF06, 8'h10, 2'd3);
        wr(16'hFF05, 8'hFE, 2'd3);
        wr(16'hFF07, 8'h05, 2'd3);
        poll(16'hFF05, 8'hFF, 40, "ovf_reach_ff");
        poll(16'hFF05, 8'h00, 40, "ovf_reach_00");
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            if (irq_timer) begin
                n = i;
                break;
            end
        end
        check("irq_delay", 16'(n), 16'd4);
        rd(16'hFF05, 8'h10, "reload_tma");
        cyc(1);
        check("irq_one_clk", 16'(irq_timer), 16'd0);

        // TIMA write during pending overflow cancels reload and interrupt
        wr(16'hFF05, 8'hFE, 2'd3);
        poll(16'hFF05, 8'h00, 48, "ovf2_reach_00");
        cyc(1);
        wr(16'hFF05, 8'h42, 2'd3);
        rd(16'hFF05, 8'h42, "pending_write");
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            seen = seen | irq_timer;
        end
        check("pending_no_irq", 16'(seen), 16'd0);

        // TMA write on the reload edge is the value loaded
        wr(16'hFF05, 8'hFF, 2'd3);
        poll(16'hFF05, 8'h00, 24, "ovf3_reach_00");
        cyc(3);
        wr(16'hFF06, 8'h77, 2'd3);
        check("irq_tma_edge", 16'(irq_timer), 16'd1);
        rd(16'hFF05, 8'h77, "reload_new_tma");

        // TIMA write on the reload edge loses to the reload
        wr(16'hFF05, 8'hFF, 2'd3);
        poll(16'hFF05, 8'h00, 24, "ovf4_reach_00");
        cyc(3);
        wr(16'hFF05, 8'h55, 2'd3);
        check("irq_tima_edge", 16'(irq_timer), 16'd1);
        rd(16'hFF05, 8'h77, "reload_beats_write");

        // DIV write while tap bit is high produces an increment
        wr(16'hFF07, 8'h00, 2'd3);
        wr(16'hFF04, 8'h00, 2'd3);
        wr(16'hFF07, 8'h04, 2'd3);
        wr(16'hFF05, 8'h20, 2'd3);
        wait_div9("div9_high_a");
        wr(16'hFF04, 8'h5A, 2'd3);
        rd(16'hFF04, 8'h00, "div_cleared");
        cyc(1);
        rd(16'hFF05, 8'h21, "div_write_tick");

        // TAC disable while tick is high produces an increment
        wait_div9("div9_high_b");
        wr(16'hFF07, 8'h00, 2'd3);
        cyc(1);
        rd(16'hFF05, 8'h22, "tac_write_tick");

        // Reset during pending overflow
        wr(16'hFF07, 8'h05, 2'd3);
        wr(16'hFF06, 8'h33, 2'd3);
        wr(16'hFF05, 8'hFF, 2'd3);
        poll(16'hFF05, 8'h00, 24, "ovf5_reach_00");
        cyc(1);
        reset = 1'b0;
        #1;
        rd(16'hFF04, 8'h00, "midrst_div");
        rd(16'hFF06, 8'h00, "midrst_tma");
        rd(16'hFF07, 8'hF8, "midrst_tac");
        check("midrst_irq", 16'(irq_timer), 16'd0);
        cyc(2);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            seen = seen | irq_timer;
        end
        check("post_rst_no_irq", 16'(seen), 16'd0);
        rd(16'hFF05, 8'h00, "post_rst_tima");
        mem_enable = 1'b0;
        #1;
        check("post_rst_unselected", 16'(mem_data_out), 16'h00FF);

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 Parameter RELOAD_DELAY, default 4, SHALL set the clk cycles from TIMA overflow to the TMA reload and interrupt (one M-cycle).
REQ-002 clk  input  1  system clock (4 MHz, same clock as the CPU).
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 t_cycle  input  2  CPU T-cycle phase; a bus write commits on the clk edge where t_cycle==3.
REQ-005 mem_addr  input  16  CPU bus address.
REQ-006 mem_enable  input  1  CPU bus access enable.
REQ-007 mem_write  input  1  CPU bus write enable.
REQ-008 mem_data_in  input  8  write data from the CPU (the CPU's mem_data_out).
REQ-009 mem_data_out  output  8  read data for the addressed timer register; 0xFF when not selected.
REQ-010 mem_select  output  1  high when mem_enable and mem_addr is in 0xFF04..0xFF07.
REQ-011 irq_timer  output  1  one-clk pulse requesting the timer interrupt.

Function
REQ-012 A 16-bit divider counter SHALL increment by 1 every clk and wrap 0xFFFF->0x0000.
REQ-013 DIV (0xFF04) SHALL read as divider[15:8].
REQ-014 Any committed write to 0xFF04 SHALL clear all 16 divider bits, regardless of data.
REQ-015 TIMA (0xFF05), TMA (0xFF06) and TAC (0xFF07, bits 2:0) SHALL be 8-, 8- and 3-bit registers; TAC SHALL read as {5'b11111, TAC[2:0]}.
REQ-016 Reads SHALL be combinational from current register state with no wait states.
REQ-017 Tap bit by TAC[1:0]: 00->divider[9], 01->divider[3], 10->divider[5], 11->divider[7].
REQ-018 tick = TAC[2] AND tap bit; TIMA SHALL increment on the clk edge after tick falls 1->0, registered previous value compared with current.
REQ-019 Since tick includes TAC[2], a DIV write or TAC write that drops tick 1->0 SHALL also increment TIMA, as real hardware does.
REQ-020 On increment with TIMA==0xFF, TIMA SHALL become 0x00 and a delay counter SHALL load RELOAD_DELAY.
REQ-021 States: IDLE, OVERFLOW_PENDING (delay counter nonzero), RELOAD.
REQ-022 OVERFLOW_PENDING: TIMA reads 0x00, and the counter decrements each clk.
REQ-023 Entering RELOAD, on the edge where the counter reaches 0, TIMA SHALL load TMA, irq_timer SHALL pulse high for exactly that one clk, and the state SHALL return to IDLE.
REQ-024 A committed TIMA write during OVERFLOW_PENDING SHALL store the written value, cancel the reload and cancel the interrupt.
REQ-025 A TIMA write on the RELOAD edge SHALL be ignored; the TMA reload wins.
REQ-026 A TMA write on or before the RELOAD edge SHALL be used by the reload; on the RELOAD edge the newly written value is loaded.
REQ-027 A tick falling edge during OVERFLOW_PENDING SHALL not increment TIMA.
REQ-028 A TIMA write on the same edge as a tick increment SHALL take priority; the write value is stored and no overflow starts.
REQ-029 Writes SHALL require mem_enable, mem_write, t_cycle==3 and an address hit; writes with t_cycle!=3 SHALL have no effect.

Reset
REQ-030 While reset is low: divider=0x0000, TIMA=0x00, TMA=0x00, TAC=3'b000, state IDLE, delay counter 0, tick history 0, irq_timer=0.
REQ-031 Reset assertion SHALL take effect immediately, including mid-overflow; a pending reload and interrupt SHALL be discarded.
REQ-032 After reset, mem_data_out SHALL be 0xFF until a timer address is selected.
REQ-033 Release SHALL be synchronous to clk: the divider reads 0x0001 one clk after reset deasserts.

Verification
REQ-034 Reset, then run 256 clks -> DIV reads 0x01; run 65536 clks total -> DIV wraps to 0x00.
REQ-035 TAC=0x05, TMA=0x10, TIMA=0xFE, run 32 clks -> TIMA 0xFF then 0x00, irq_timer pulses exactly 4 clks after overflow, TIMA=0x10.
REQ-036 Overflow as in REQ-035, write TIMA=0x42 at the 2nd clk of OVERFLOW_PENDING -> TIMA=0x42, no irq_timer pulse.
REQ-037 TAC=0x04, run until divider[9]=1, then write DIV -> TIMA increments by 1 and divider=0x0000.
REQ-038 Write TAC=0x07 with t_cycle=1 -> TAC reads 0xF8; repeat with t_cycle=3 -> reads 0xFF; read 0xFF08 -> mem_select=0, data 0xFF.
REQ-039 Pull reset low during OVERFLOW_PENDING -> all registers zero immediately, no irq_timer pulse after release.
